// File: rtl/img_line_writer.sv
// Line-buffer writer: gathers a stream of words into a line and commits the whole
// line to the image memory with a single write_en strobe.
//
// state  | meaning
// IDLE   | waiting for start; no words accepted
// FILL   | accepting stream words into the line buffer
// COMMIT | write_en high for one cycle; buffer frozen
// DONE   | done pulse for one cycle; buffer frozen
module img_line_writer #(
   parameter int LINE_SIZE = 64,
   parameter int PORT_SIZE = 128,
   parameter int DATA_W    = 32
) (
   input  logic                               clk,
   input  logic                               rst_n,
   input  logic                               start,
   input  logic                               abort,
   input  logic                               in_valid,
   input  logic [DATA_W-1:0]                  in_data,
   output logic                               in_ready,
   output logic [DATA_W-1:0]                  img_out [PORT_SIZE],
   output logic                               write_en,
   output logic                               busy,
   output logic                               done,
   output logic [$clog2(LINE_SIZE+1)-1:0]     word_cnt
);

   localparam int CNT_W = $clog2(LINE_SIZE + 1);
   localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(LINE_SIZE - 1);

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      FILL   = 2'd1,
      COMMIT = 2'd2,
      DONE   = 2'd3
   } state_t;

   state_t state, state_nxt;

   logic [DATA_W-1:0] line_buf [LINE_SIZE];
   logic              accept;
   logic              store;

   assign in_ready = (state == FILL);
   assign write_en = (state == COMMIT);
   assign done     = (state == DONE);
   assign busy     = (state != IDLE);

   assign accept = in_valid & in_ready;
   // abort takes priority over a coincident accept
   assign store  = accept & ~abort;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE: begin
            if (start) state_nxt = FILL;
         end
         FILL: begin
            if (abort)
               state_nxt = IDLE;
            else if (accept && (word_cnt == LAST_IDX))
               state_nxt = COMMIT;
         end
         COMMIT:  state_nxt = DONE;
         DONE:    state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         word_cnt <= '0;
      end else if ((state == IDLE) && start) begin
         word_cnt <= '0;
      end else if ((state == FILL) && abort) begin
         word_cnt <= '0;
      end else if (store) begin
         word_cnt <= word_cnt + CNT_W'(1);
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < LINE_SIZE; i++) line_buf[i] <= '0;
      end else if (store) begin
         for (int i = 0; i < LINE_SIZE; i++) begin
            if (CNT_W'(i) == word_cnt) line_buf[i] <= in_data;
         end
      end
   end

   // entries beyond the line length are never written and read as zero
   for (genvar g = 0; g < PORT_SIZE; g++) begin : g_port
      if (g < LINE_SIZE) begin : g_used
         assign img_out[g] = line_buf[g];
      end else begin : g_zero
         assign img_out[g] = '0;
      end
   end

endmodule

// File: tb/tb_img_line_writer.sv
// Directed bench for img_line_writer: full line, gapped stream, abort,
// ignored controls and asynchronous reset during commit.
module tb_img_line_writer;

   logic        clk;
   logic        rst_n;
   logic        start;
   logic        abort;
   logic        in_valid;
   logic [31:0] in_data;
   logic        in_ready;
   logic [31:0] img_out [128];
   logic        write_en;
   logic        busy;
   logic        done;
   logic [6:0]  word_cnt;

   int n_cmp = 0;
   int n_bad = 0;
   int we_cycles = 0;
   int done_cycles = 0;

   img_line_writer #(.LINE_SIZE(64), .PORT_SIZE(128), .DATA_W(32)) dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .start    (start),
      .abort    (abort),
      .in_valid (in_valid),
      .in_data  (in_data),
      .in_ready (in_ready),
      .img_out  (img_out),
      .write_en (write_en),
      .busy     (busy),
      .done     (done),
      .word_cnt (word_cnt)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always @(negedge clk) begin
      if (write_en === 1'b1) we_cycles++;
      if (done === 1'b1) done_cycles++;
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_start();
      start = 1'b1;
      tick();
      start = 1'b0;
   endtask

   task automatic test_reset();
      rst_n = 1'b0; start = 1'b0; abort = 1'b0; in_valid = 1'b0; in_data = '0;
      #3;
      n_cmp++;
      if ({write_en, done, in_ready, busy} !== 4'b0000) begin
         n_bad++; $display("FAIL reset_ctrl: got %b want 0000", {write_en, done, in_ready, busy});
      end
      n_cmp++;
      if (word_cnt !== 7'd0) begin
         n_bad++; $display("FAIL reset_word_cnt: got %0d want 0", word_cnt);
      end
      for (int i = 0; i < 128; i++) begin
         n_cmp++;
         if (img_out[i] !== 32'h0) begin
            n_bad++; $display("FAIL reset_img[%0d]: got %h want 0", i, img_out[i]);
         end
      end
      #9 rst_n = 1'b1;
      tick();
   endtask

   task automatic test_full_line();
      int we0;
      int dn0;
      we0 = we_cycles; dn0 = done_cycles;
      do_start();
      n_cmp++;
      if (in_ready !== 1'b1 || busy !== 1'b1) begin
         n_bad++; $display("FAIL full_fill_entry: in_ready=%b busy=%b want 1 1", in_ready, busy);
      end
      for (int i = 0; i < 64; i++) begin
         in_valid = 1'b1;
         in_data  = 32'h1000_0000 + i;
         if (i == 63) begin
            n_cmp++;
            if (write_en !== 1'b0) begin
               n_bad++; $display("FAIL full_we_early: got %b want 0", write_en);
            end
         end
         tick();
      end
      in_valid = 1'b0;
      n_cmp++;
      if (write_en !== 1'b1 || in_ready !== 1'b0 || done !== 1'b0) begin
         n_bad++; $display("FAIL full_commit: we=%b rdy=%b done=%b want 1 0 0", write_en, in_ready, done);
      end
      n_cmp++;
      if (word_cnt !== 7'd64) begin
         n_bad++; $display("FAIL full_word_cnt: got %0d want 64", word_cnt);
      end
      tick();
      n_cmp++;
      if (write_en !== 1'b0 || done !== 1'b1 || busy !== 1'b1) begin
         n_bad++; $display("FAIL full_done: we=%b done=%b busy=%b want 0 1 1", write_en, done, busy);
      end
      tick();
      n_cmp++;
      if (done !== 1'b0 || busy !== 1'b0 || in_ready !== 1'b0 || word_cnt !== 7'd64) begin
         n_bad++; $display("FAIL full_idle: done=%b busy=%b rdy=%b cnt=%0d want 0 0 0 64", done, busy, in_ready, word_cnt);
      end
      for (int i = 0; i < 128; i++) begin
         n_cmp++;
         if (img_out[i] !== ((i < 64) ? 32'h1000_0000 + i : 32'h0)) begin
            n_bad++; $display("FAIL full_img[%0d]: got %h want %h", i, img_out[i], (i < 64) ? 32'h1000_0000 + i : 32'h0);
         end
      end
      n_cmp++;
      if (we_cycles - we0 !== 1 || done_cycles - dn0 !== 1) begin
         n_bad++; $display("FAIL full_pulse_count: we=%0d done=%0d want 1 1", we_cycles - we0, done_cycles - dn0);
      end
   endtask

   task automatic test_gapped();
      int we0;
      rst_n = 1'b0; #2 rst_n = 1'b1;
      tick();
      we0 = we_cycles;
      do_start();
      for (int i = 0; i < 64; i++) begin
         in_valid = 1'b1;
         in_data  = 32'h1000_0000 + i;
         tick();
         in_valid = 1'b0;
         in_data  = 32'hDEAD_BEEF;
         if (i < 63) begin
            tick();
            if (i == 20) begin
               n_cmp++;
               if (word_cnt !== 7'd21 || write_en !== 1'b0 || in_ready !== 1'b1) begin
                  n_bad++; $display("FAIL gap_hold: cnt=%0d we=%b rdy=%b want 21 0 1", word_cnt, write_en, in_ready);
               end
            end
         end
      end
      n_cmp++;
      if (write_en !== 1'b1) begin
         n_bad++; $display("FAIL gap_commit: got %b want 1", write_en);
      end
      tick();
      tick();
      tick();
      for (int i = 0; i < 128; i++) begin
         n_cmp++;
         if (img_out[i] !== ((i < 64) ? 32'h1000_0000 + i : 32'h0)) begin
            n_bad++; $display("FAIL gap_img[%0d]: got %h want %h", i, img_out[i], (i < 64) ? 32'h1000_0000 + i : 32'h0);
         end
      end
      n_cmp++;
      if (we_cycles - we0 !== 1) begin
         n_bad++; $display("FAIL gap_we_count: got %0d want 1", we_cycles - we0);
      end
   endtask

   task automatic test_abort();
      int we0;
      we0 = we_cycles;
      do_start();
      for (int i = 0; i < 10; i++) begin
         in_valid = 1'b1;
         in_data  = 32'h2000_0000 + i;
         tick();
      end
      in_data = 32'h2000_000A;
      abort   = 1'b1;
      tick();
      abort = 1'b0; in_valid = 1'b0;
      n_cmp++;
      if (busy !== 1'b0 || in_ready !== 1'b0 || word_cnt !== 7'd0) begin
         n_bad++; $display("FAIL abort_idle: busy=%b rdy=%b cnt=%0d want 0 0 0", busy, in_ready, word_cnt);
      end
      n_cmp++;
      if (img_out[10] !== 32'h1000_000A) begin
         n_bad++; $display("FAIL abort_img10: got %h want 1000000a", img_out[10]);
      end
      n_cmp++;
      if (img_out[9] !== 32'h2000_0009 || img_out[11] !== 32'h1000_000B) begin
         n_bad++; $display("FAIL abort_neighbours: got %h %h want 20000009 1000000b", img_out[9], img_out[11]);
      end
      tick();
      tick();
      n_cmp++;
      if (we_cycles - we0 !== 0 || busy !== 1'b0) begin
         n_bad++; $display("FAIL abort_no_write: we=%0d busy=%b want 0 0", we_cycles - we0, busy);
      end
   endtask

   task automatic test_ignored_controls();
      in_valid = 1'b1;
      in_data  = 32'hBAD0_BAD0;
      tick();
      n_cmp++;
      if (in_ready !== 1'b0 || word_cnt !== 7'd0 || img_out[0] !== 32'h2000_0000) begin
         n_bad++; $display("FAIL idle_no_accept: rdy=%b cnt=%0d img0=%h want 0 0 20000000", in_ready, word_cnt, img_out[0]);
      end
      in_valid = 1'b0;
      do_start();
      for (int i = 0; i < 5; i++) begin
         in_valid = 1'b1;
         in_data  = 32'h3000_0000 + i;
         tick();
      end
      n_cmp++;
      if (word_cnt !== 7'd5) begin
         n_bad++; $display("FAIL ign_cnt5: got %0d want 5", word_cnt);
      end
      start   = 1'b1;
      in_data = 32'h3000_0005;
      tick();
      start = 1'b0; in_valid = 1'b0;
      n_cmp++;
      if (word_cnt !== 7'd6 || img_out[5] !== 32'h3000_0005 || img_out[0] !== 32'h3000_0000) begin
         n_bad++; $display("FAIL ign_start: cnt=%0d img5=%h img0=%h want 6 30000005 30000000", word_cnt, img_out[5], img_out[0]);
      end
      abort = 1'b1;
      tick();
      abort = 1'b0;
      n_cmp++;
      if (busy !== 1'b0 || word_cnt !== 7'd0) begin
         n_bad++; $display("FAIL ign_cleanup: busy=%b cnt=%0d want 0 0", busy, word_cnt);
      end
   endtask

   task automatic test_reset_mid_commit();
      int dn0;
      dn0 = done_cycles;
      do_start();
      for (int i = 0; i < 64; i++) begin
         in_valid = 1'b1;
         in_data  = 32'h4000_0000 + i;
         tick();
      end
      in_valid = 1'b0;
      n_cmp++;
      if (write_en !== 1'b1) begin
         n_bad++; $display("FAIL rst_commit_pre: got %b want 1", write_en);
      end
      rst_n = 1'b0;
      #1;
      n_cmp++;
      if (write_en !== 1'b0 || busy !== 1'b0 || done !== 1'b0 || word_cnt !== 7'd0) begin
         n_bad++; $display("FAIL rst_commit_ctrl: we=%b busy=%b done=%b cnt=%0d want 0 0 0 0", write_en, busy, done, word_cnt);
      end
      for (int i = 0; i < 128; i++) begin
         n_cmp++;
         if (img_out[i] !== 32'h0) begin
            n_bad++; $display("FAIL rst_commit_img[%0d]: got %h want 0", i, img_out[i]);
         end
      end
      tick();
      rst_n = 1'b1;
      tick();
      tick();
      n_cmp++;
      if (done_cycles - dn0 !== 0 || busy !== 1'b0) begin
         n_bad++; $display("FAIL rst_commit_no_done: done=%0d busy=%b want 0 0", done_cycles - dn0, busy);
      end
   endtask

   initial begin
      test_reset();
      test_full_line();
      test_gapped();
      test_abort();
      test_ignored_controls();
      test_reset_mid_commit();
      n_cmp++;
      if (we_cycles !== 2) begin
         n_bad++; $display("FAIL total_writes: got %0d want 2", we_cycles);
      end
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
